// File: rtl/traffic_display_if.sv
// traffic_display_if: phase/countdown inputs and scanned 7-segment outputs of the display.
interface traffic_display_if;
    logic [1:0] state;
    logic [5:0] A_time;
    logic [5:0] B_time;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;
    modport master (output state, A_time, B_time, input an, seg, frame_done);
    modport slave  (input state, A_time, B_time, output an, seg, frame_done);
endinterface

// File: rtl/traffic_display.sv
// traffic_display: multiplexes the road A/B countdowns onto four active-low 7-segment digits,
// with per-frame input snapshots, leading-zero blanking, dash for 60..63 and yellow-phase blinking.
module traffic_display #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input logic              CLK,
    input logic              RSTn,
    traffic_display_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    snap_state_q, snap_state_d;
    logic [5:0]    snap_a_q, snap_a_d;
    logic [5:0]    snap_b_q, snap_b_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d, cnt_inc;
    logic          phase_on_q, phase_on_d;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick, wrap, state_chg, half_done;
    logic          road_b, blank, dp_n;
    logic [5:0]    val, digit;
    logic [6:0]    glyph;

    function automatic logic [6:0] seg7(input logic [5:0] v);
        case (v)
            6'd0:    seg7 = 7'b1000000;
            6'd1:    seg7 = 7'b1111001;
            6'd2:    seg7 = 7'b0100100;
            6'd3:    seg7 = 7'b0110000;
            6'd4:    seg7 = 7'b0011001;
            6'd5:    seg7 = 7'b0010010;
            6'd6:    seg7 = 7'b0000010;
            6'd7:    seg7 = 7'b1111000;
            6'd8:    seg7 = 7'b0000000;
            6'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick         = presc_q == PW'(SCAN_DIV - 1);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        wrap         = tick && idx_q == 2'd3;
        frame_done_d = wrap;
        snap_state_d = wrap ? bus.state  : snap_state_q;
        snap_a_d     = wrap ? bus.A_time : snap_a_q;
        snap_b_d     = wrap ? bus.B_time : snap_b_q;
        // A phase change restarts blinking in the visible half.
        state_chg    = bus.state != snap_state_q;
        cnt_inc      = blink_cnt_q + 1'b1;
        half_done    = cnt_inc == BW'(BLINK_FRAMES);
        blink_cnt_d  = !wrap ? blink_cnt_q : (state_chg || half_done) ? '0 : cnt_inc;
        phase_on_d   = !wrap ? phase_on_q : state_chg ? 1'b1 : half_done ? ~phase_on_q : phase_on_q;
        road_b       = idx_q[1];
        val          = road_b ? snap_b_q : snap_a_q;
        digit        = idx_q[0] ? val % 6'd10 : val / 6'd10;
        glyph        = (val >= 6'd60) ? 7'b0111111 :
                       (!idx_q[0] && digit == 6'd0) ? 7'b1111111 : seg7(digit);
        blank        = !phase_on_q && snap_state_q[0] && snap_state_q[1] == road_b;
        dp_n         = !((idx_q == 2'd1 && snap_state_q == 2'b00) ||
                         (idx_q == 2'd3 && snap_state_q == 2'b10));
        seg_d        = blank ? 8'hFF : {dp_n, glyph};
        an_d         = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q      <= '0;
            idx_q        <= 2'd3;
            snap_state_q <= '0;
            snap_a_q     <= '0;
            snap_b_q     <= '0;
            blink_cnt_q  <= '0;
            phase_on_q   <= 1'b1;
            frame_done_q <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 8'hFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_state_q <= snap_state_d;
            snap_a_q     <= snap_a_d;
            snap_b_q     <= snap_b_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_on_q   <= phase_on_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_traffic_display.sv
// tb_traffic_display: directed and randomized checks of traffic_display against a frame-level model.
module tb_traffic_display;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = 4 * SD;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    traffic_display_if bus();

    traffic_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails = 0;
    int n = 0;
    int run = 1;
    logic [1:0] m_st = 2'd0;
    logic [5:0] m_a = 6'd0;
    logic [5:0] m_b = 6'd0;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;
    logic [7:0] cap [4];
    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Expected pattern for digit d, using the snapshot and blink run length held by the model.
    function automatic logic [7:0] model_seg(input int d);
        int v, dig;
        logic dp;
        logic [6:0] low;
        v = (d < 2) ? int'(m_a) : int'(m_b);
        if (((run - 1) / BF) % 2 == 1 && m_st == ((d < 2) ? 2'd1 : 2'd3)) return 8'hFF;
        dp = !((d == 1 && m_st == 2'd0) || (d == 3 && m_st == 2'd2));
        dig = (d % 2 == 0) ? v / 10 : v % 10;
        low = (v >= 60) ? 7'h3F : (d % 2 == 0 && dig == 0) ? 7'h7F : codes[dig];
        return {dp, low};
    endfunction

    task automatic step();
        int d;
        @(posedge CLK);
        n++;
        d = (3 + (n - 1) / SD) % 4;
        exp_an = ~(4'b0001 << d);
        exp_seg = model_seg(d);
        exp_fd = n >= SD && (n - SD) % FR == 0;
        if (exp_fd) begin
            run = (bus.state != m_st) ? 1 : run + 1;
            m_st = bus.state;
            m_a = bus.A_time;
            m_b = bus.B_time;
        end
        #1;
    endtask

    task automatic model_reset();
        n = 0;
        run = 1;
        m_st = 2'd0;
        m_a = 6'd0;
        m_b = 6'd0;
    endtask

    task automatic wait_frame(input string name);
        bit found = 0;
        for (int i = 0; i <= FR && !found; i++) begin
            step();
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                fails++;
                $display("FAIL %s n=%0d an=%b want %b seg=%h want %h fd=%b want %b", name, n, bus.an, exp_an, bus.seg, exp_seg, bus.frame_done, exp_fd);
            end
            checks++;
            found = bus.frame_done === 1'b1;
        end
        if (!found) begin
            fails++;
            $display("FAIL %s_sync frame_done=0 want 1 within %0d cycles", name, FR + 1);
        end
        checks++;
    endtask

    task automatic run_frame(input string name, input int chg_at, input logic [5:0] chg_a);
        for (int i = 1; i <= FR; i++) begin
            step();
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                fails++;
                $display("FAIL %s n=%0d an=%b want %b seg=%h want %h fd=%b want %b", name, n, bus.an, exp_an, bus.seg, exp_seg, bus.frame_done, exp_fd);
            end
            checks++;
            for (int k = 0; k < 4; k++) if (bus.an[k] === 1'b0) cap[k] = bus.seg;
            if (i == chg_at) bus.A_time = chg_a;
        end
    endtask

    task automatic test_reset();
        bus.state = 2'd0;
        bus.A_time = 6'd0;
        bus.B_time = 6'd0;
        RSTn = 1'b0;
        #18;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold an=%b seg=%h fd=%b want 1111/ff/0", bus.an, bus.seg, bus.frame_done);
        end
        checks++;
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                fails++;
                $display("FAIL reset_seq n=%0d an=%b want %b seg=%h want %h fd=%b want %b", n, bus.an, exp_an, bus.seg, exp_seg, bus.frame_done, exp_fd);
            end
            checks++;
            if (n == SD && bus.frame_done !== 1'b1) begin
                fails++;
                $display("FAIL first_tick fd=%b want 1 after edge %0d", bus.frame_done, n);
            end
            if (n == SD + 1 && bus.an !== 4'b1110) begin
                fails++;
                $display("FAIL first_digit0 an=%b want 1110 after edge %0d", bus.an, n);
            end
            if (n == SD || n == SD + 1) checks++;
        end
    endtask

    task automatic test_digits();
        bus.state = 2'b00;
        bus.A_time = 6'd25;
        bus.B_time = 6'd7;
        wait_frame("digits_sync");
        run_frame("digits", 0, 6'd0);
        if (cap[0] !== 8'hA4 || cap[1] !== 8'h12 || cap[2] !== 8'hFF || cap[3] !== 8'hF8) begin
            fails++;
            $display("FAIL digits_frame got %h %h %h %h want a4 12 ff f8", cap[0], cap[1], cap[2], cap[3]);
        end
        checks++;
    endtask

    task automatic test_dash();
        bus.state = 2'b11;
        bus.A_time = 6'd63;
        bus.B_time = 6'd60;
        wait_frame("dash_sync");
        run_frame("dash", 0, 6'd0);
        if (cap[0] !== 8'hBF || cap[1] !== 8'hBF || cap[2] !== 8'hBF || cap[3] !== 8'hBF) begin
            fails++;
            $display("FAIL dash_frame got %h %h %h %h want bf bf bf bf", cap[0], cap[1], cap[2], cap[3]);
        end
        checks++;
    endtask

    task automatic test_blink();
        logic [7:0] want;
        bus.state = 2'b01;
        bus.A_time = 6'd25;
        bus.B_time = 6'd7;
        wait_frame("blink_sync");
        for (int f = 1; f <= 6; f++) begin
            run_frame("blink", 0, 6'd0);
            want = (f == 3 || f == 4) ? 8'hFF : 8'h92;
            if (cap[1] !== want || cap[3] !== 8'hF8) begin
                fails++;
                $display("FAIL blink_frame%0d a_units=%h want %h b_units=%h want f8", f, cap[1], want, cap[3]);
            end
            checks++;
        end
        bus.state = 2'b11;
        run_frame("blink_last01", 0, 6'd0);
        run_frame("blink_restart", 0, 6'd0);
        if (cap[3] !== 8'hF8 || cap[1] !== 8'h92) begin
            fails++;
            $display("FAIL blink_restart b_units=%h want f8 a_units=%h want 92", cap[3], cap[1]);
        end
        checks++;
    endtask

    task automatic test_midframe();
        bus.state = 2'b00;
        bus.A_time = 6'd25;
        bus.B_time = 6'd7;
        wait_frame("mid_sync");
        run_frame("mid", SD + 1, 6'd24);
        if (cap[1] !== 8'h12) begin
            fails++;
            $display("FAIL mid_same_frame digit1=%h want 12", cap[1]);
        end
        checks++;
        run_frame("mid_next", 0, 6'd0);
        if (cap[1] !== 8'h19) begin
            fails++;
            $display("FAIL mid_next_frame digit1=%h want 19", cap[1]);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        wait_frame("rmid_sync");
        for (int i = 0; i < 2 * SD + 1; i++) step();
        if (bus.an !== 4'b1011) begin
            fails++;
            $display("FAIL rmid_digit2 an=%b want 1011", bus.an);
        end
        checks++;
        #1 RSTn = 1'b0;
        #1;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL rmid_async an=%b seg=%h fd=%b want 1111/ff/0", bus.an, bus.seg, bus.frame_done);
        end
        checks++;
        #20;
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        for (int i = 0; i < FR + 2; i++) begin
            step();
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                fails++;
                $display("FAIL rmid_seq n=%0d an=%b want %b seg=%h want %h fd=%b want %b", n, bus.an, exp_an, bus.seg, exp_seg, bus.frame_done, exp_fd);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40 * FR; i++) begin
            step();
            if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_done !== exp_fd) begin
                fails++;
                $display("FAIL random n=%0d an=%b want %b seg=%h want %h fd=%b want %b", n, bus.an, exp_an, bus.seg, exp_seg, bus.frame_done, exp_fd);
            end
            checks++;
            if ($urandom_range(0, 47) == 0) bus.state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) bus.A_time = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) bus.B_time = 6'($urandom_range(0, 63));
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_dash();
        test_blink();
        test_midframe();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/traffic_display.md
TRAFFIC_DISPLAY -- requirements
Module: traffic_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, meaning clocks per digit slot (>=2).
REQ-002 Parameter BLINK_FRAMES, default 8, meaning scan frames per blink half-period (>=1).
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 state  input  2  controller phase: 00 A green, 01 A yellow, 10 B green, 11 B yellow.
REQ-006 A_time  input  6  road-A countdown, unsigned binary seconds.
REQ-007 B_time  input  6  road-B countdown, unsigned binary seconds.
REQ-008 an  output  4  digit enables, active-low; an[0] A tens, an[1] A units, an[2] B tens, an[3] B units.
REQ-009 seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-010 frame_done  output  1  one-cycle pulse at each frame snapshot.

Function
REQ-011 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = prescaler at SCAN_DIV-1.
REQ-012 The digit index SHALL advance on tick, 0->1->2->3->0; its reset value is 3.
REQ-013 On the tick that wraps the index 3->0, the block SHALL snapshot state, A_time and B_time, and SHALL set frame_done high for exactly that one following cycle.
REQ-014 Displayed content SHALL come only from the snapshot; input changes mid-frame SHALL NOT alter the current frame.
REQ-015 an and seg SHALL be registered from the digit index and snapshot, lagging the index by one clock; exactly one an bit is low when not in reset.
REQ-016 Each time value SHALL be split into tens = value/10 and units = value%10, both 0..9.
REQ-017 Segment codes (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 A tens digit of 0 SHALL be blanked (seg[6:0]=1111111); units digit always shown.
REQ-019 A value of 60..63 SHALL display dash (seg[6:0]=0111111) on both digits of that road.
REQ-020 dp (seg[7]=0) SHALL be lit on digit 1 when snapshot state=00, on digit 3 when snapshot state=10; otherwise seg[7]=1.
REQ-021 The blink counter SHALL count frames; blink phase SHALL toggle every BLINK_FRAMES frames, starting ON.
REQ-022 In phase OFF with snapshot state 01, digits 0 and 1 SHALL read seg=8'hFF; state 11 likewise blanks digits 2 and 3; the other road is unaffected.
REQ-023 When a new snapshot state differs from the previous snapshot state, the blink counter SHALL clear and the phase SHALL return to ON in the same cycle.
REQ-024 Blanking SHALL have priority over dash, dash over digit codes.

Reset
REQ-025 While RSTn=0: an=4'b1111, seg=8'hFF, frame_done=0, prescaler=0, index=3, snapshot=0, blink counter=0, phase ON.
REQ-026 Reset SHALL take effect immediately, including mid-frame, without waiting for CLK.
REQ-027 After release, the first tick SHALL occur on rising edge SCAN_DIV; an=4'b1110 SHALL first appear after edge SCAN_DIV+1.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 RSTn=0 for 20 ns then 1 -> an=1111, seg=FF during reset; frame_done pulse after edge 4; an=1110 after edge 5.
REQ-029 state=00, A_time=25, B_time=7 -> digit0 seg=8'hA4, digit1 seg=8'h12 (dp on), digit2 seg=8'hFF, digit3 seg=8'hF8.
REQ-030 A_time=63, B_time=60 -> all four digits seg=8'hBF.
REQ-031 state=01 held -> A digits visible frames 1-2, 8'hFF frames 3-4, visible 5-6; B digits never blank; switch to 11 -> phase restarts ON.
REQ-032 A_time changed 25->24 while digit 1 active -> digit 1 still shows 5 in that frame; 4 from next frame.
REQ-033 RSTn pulsed low while digit 2 active -> an=1111, seg=FF within the same cycle; sequence restarts per REQ-027.
